nios2_system_cpu_div_cell: RTL
==============================

Name: nios2_system_cpu_div_cell

Overview:
- Iterative 32-bit integer divider for the Nios II CPU datapath; the inverse of the multiply cell.
- Accepts div/divu operands from the E stage and runs a radix-2 restoring algorithm, one quotient bit per cycle.
- Returns quotient and remainder to the M-stage writeback mux at a fixed latency.
- The pipeline stalls on busy and captures the result on done.

Parameters:
- DATA_WIDTH, 32: operand/result width; even, >= 4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- E_div_start  in  1  start request; sampled only in IDLE.
- E_div_signed  in  1  1 = signed (div), 0 = unsigned (divu); sampled with start.
- E_src1  in  DATA_WIDTH  dividend; sampled with start.
- E_src2  in  DATA_WIDTH  divisor; sampled with start.
- M_div_abort  in  1  cancels the in-flight operation (pipeline flush).
- M_div_busy  out  1  high from the cycle after an accepted start until return to IDLE.
- M_div_done  out  1  one-cycle pulse; results are valid in this cycle.
- M_div_quot  out  DATA_WIDTH  quotient; held until the next accepted start.
- M_div_rem  out  DATA_WIDTH  remainder; held until the next accepted start.

Behaviour:
- Reset (async, any state): state = IDLE; all outputs and internal registers = 0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - E_div_start=1 and M_div_abort=0: load |dividend|, |divisor| (absolute values only when signed), sign flags, zero-divisor flag and overflow flag; clear the partial remainder; count = DATA_WIDTH-1; go to CALC.
  - Start together with abort: abort wins, the start is ignored, stay in IDLE.
- CALC, one cycle per bit:
  - shift the {rem, dividend} pair left by 1.
  - Trial subtract the divisor from rem (DATA_WIDTH+1-bit subtract).
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise keep rem and shift in 0.
  - Stays exactly DATA_WIDTH cycles; when count = 0, go to FIX.
- FIX, one cycle:
  - Signed: negate the quotient if the operand signs differ; the remainder takes the dividend's sign (truncating division).
  - Divisor = 0: quot = all ones, rem = original E_src1 (both modes).
  - Signed overflow (dividend = 1 followed by zeros, divisor = all ones): quot = dividend value, rem = 0.
  - Register the results into M_div_quot and M_div_rem; go to DONE.
- DONE: M_div_done = 1 for exactly one cycle; busy = 0 in this cycle; next state IDLE.
  - A start asserted in the DONE cycle is ignored.
  - The requester waits for IDLE before issuing the next start.
- Latency:
  - Start cycle = cycle 0.
  - busy high in cycles 1..DATA_WIDTH+1.
  - done high in cycle DATA_WIDTH+2 (cycle 34 for DATA_WIDTH = 32).
  - Constant latency for all operands, including the zero-divisor and overflow cases.
- M_div_abort high in CALC or FIX: next state IDLE, no done pulse, M_div_quot/M_div_rem keep their previous values, busy drops the next cycle.
- M_div_abort in DONE: the done pulse still completes.
- E_div_start while busy: ignored, with no side effect on the in-flight operation.
- Operand inputs are don't-care except in the accepted start cycle.
- No combinational path from any input to any output.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> busy cycles 1-33; done at cycle 34 with quot = 14, rem = 2; outputs held after done.
- Signed 0xFFFFFFF9 (-7) / 2 -> quot = 0xFFFFFFFD (-3), rem = 0xFFFFFFFF (-1).
- Signed 7 / 0xFFFFFFFE (-2) -> quot = 0xFFFFFFFD, rem = 1.
- Unsigned 0xFFFFFFFF / 1 -> quot = 0xFFFFFFFF, rem = 0.
- Divide-by-zero, 0x00001234 / 0 in both modes -> quot = 0xFFFFFFFF, rem = 0x00001234, done at cycle 34.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quot = 0x80000000, rem = 0, done at cycle 34.
- Abort and restart:
  - Start 1000 / 3; assert M_div_abort at cycle 10 -> busy = 0 from cycle 11, no done, outputs unchanged.
  - Start 50 / 5 at cycle 12 -> done at cycle 46 with quot = 10, rem = 0.
- Start while busy: a second start at cycle 5 with different operands -> ignored; the first result is returned at cycle 34.
- Reset mid-operation: assert reset at cycle 20, asynchronously between edges -> all outputs 0 immediately, state IDLE, no done pulse; a fresh start after release divides correctly.

Source files
------------

// File: rtl/nios2_system_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu: one quotient bit per cycle,
// fixed latency of DATA_WIDTH+2 cycles from the accepted start to the done pulse.
module nios2_system_cpu_div_cell #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  E_div_start,
   input  logic                  E_div_signed,
   input  logic [DATA_WIDTH-1:0] E_src1,
   input  logic [DATA_WIDTH-1:0] E_src2,
   input  logic                  M_div_abort,
   output logic                  M_div_busy,
   output logic                  M_div_done,
   output logic [DATA_WIDTH-1:0] M_div_quot,
   output logic [DATA_WIDTH-1:0] M_div_rem
);

   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] rem, dvd, dvs;
   logic                  neg_q, neg_r, zero_div, ovf;
   logic [CW-1:0]         count;

   logic                  accept;
   logic                  a_neg, b_neg;
   logic [DATA_WIDTH-1:0] a_abs, b_abs;
   logic [DATA_WIDTH:0]   part, trial;
   logic                  trial_ok;
   logic [DATA_WIDTH-1:0] q_fix, r_fix;

   always_comb begin
      accept   = E_div_start & ~M_div_abort;
      a_neg    = E_div_signed & E_src1[DATA_WIDTH-1];
      b_neg    = E_div_signed & E_src2[DATA_WIDTH-1];
      a_abs    = a_neg ? -E_src1 : E_src1;
      b_abs    = b_neg ? -E_src2 : E_src2;
      // part is one bit wider than rem; a set top bit alone guarantees part >= dvs
      part     = {rem, dvd[DATA_WIDTH-1]};
      trial    = part - {1'b0, dvs};
      trial_ok = part[DATA_WIDTH] | ~trial[DATA_WIDTH];
      // with a zero divisor rem ends as |dividend|, so the sign fix-up restores E_src1
      q_fix    = neg_q ? -dvd : dvd;
      r_fix    = neg_r ? -rem : rem;
      if (zero_div) begin
         q_fix = '1;
      end else if (ovf) begin
         q_fix = MIN_NEG;
         r_fix = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_CALC;
         S_CALC:  if (M_div_abort) state_nxt = S_IDLE;
                  else if (count == '0) state_nxt = S_FIX;
         S_FIX:   state_nxt = M_div_abort ? S_IDLE : S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      M_div_busy = (state == S_CALC) || (state == S_FIX);
      M_div_done = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem        <= '0;
         dvd        <= '0;
         dvs        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         zero_div   <= 1'b0;
         ovf        <= 1'b0;
         count      <= '0;
         M_div_quot <= '0;
         M_div_rem  <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               rem      <= '0;
               dvd      <= a_abs;
               dvs      <= b_abs;
               neg_q    <= a_neg ^ b_neg;
               neg_r    <= a_neg;
               zero_div <= (E_src2 == '0);
               ovf      <= E_div_signed && (E_src1 == MIN_NEG) && (E_src2 == '1);
               count    <= CW'(DATA_WIDTH - 1);
            end
            S_CALC: begin
               rem   <= trial_ok ? trial[DATA_WIDTH-1:0] : part[DATA_WIDTH-1:0];
               dvd   <= {dvd[DATA_WIDTH-2:0], trial_ok};
               count <= count - CW'(1);
            end
            S_FIX: if (!M_div_abort) begin
               M_div_quot <= q_fix;
               M_div_rem  <= r_fix;
            end
            default: ;
         endcase
      end
   end

endmodule
